// File: rtl/pio_in_debounce_irq_pkg.sv
// pio_pkg: shared register map and edge-type encodings for the debounced input PIO
package pio_pkg;
    localparam logic [1:0] DATA    = 2'd0;
    localparam logic [1:0] RSVD    = 2'd1;
    localparam logic [1:0] IRQMASK = 2'd2;
    localparam logic [1:0] EDGECAP = 2'd3;
    localparam int RISE = 0;
    localparam int FALL = 1;
    localparam int ANY  = 2;
    function automatic logic edge_match(input int edge_type, input logic new_level);
        return new_level ? (edge_type != FALL) : (edge_type != RISE);
    endfunction
endpackage

// File: rtl/pio_in_debounce_irq_if.sv
// pio_in_debounce_irq_if: Avalon-MM s1 slave bus plus interrupt line
interface pio_in_debounce_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_in_debounce_irq_debounce.sv
// pio_debounce_bit: synchroniser, debounce counter and stable flop for one input bit
module pio_debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic update
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;
    assign synced = sync[SYNC_STAGES-1];
    // update fires on the edge where stable takes the new level; the new level is ~stable
    assign update = (synced != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    // shift the raw input through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= {SYNC_STAGES{RESET_VALUE}};
        else          sync <= {sync[SYNC_STAGES-2:0], din};
    end
    // count consecutive disagreeing cycles and accept the new level once held long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= RESET_VALUE;
            cnt    <= '0;
        end else if (synced == stable) begin
            cnt    <= '0;
        end else if (update) begin
            stable <= synced;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pio_in_debounce_irq.sv
// pio_in_debounce_irq: debounced input PIO with sticky edge capture and maskable irq
module pio_in_debounce_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pio_in_debounce_irq_if.slave  s1,
    input  logic [WIDTH-1:0]      in_port
);
    logic [WIDTH-1:0] stable, update, edge_set, edge_clr, irqmask, edgecap, rd_sel;
    logic             wr;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .stable (stable[i]),
            .update (update[i])
        );
    end
    assign wr       = s1.chipselect && !s1.write_n;
    assign edge_clr = (wr && s1.address == EDGECAP) ? s1.writedata[WIDTH-1:0] : '0;
    assign rd_sel   = s1.address == DATA    ? stable  :
                      s1.address == IRQMASK ? irqmask :
                      s1.address == EDGECAP ? edgecap : '0;
    assign s1.irq   = |(edgecap & irqmask);
    // keep only stable updates whose direction matches the configured edge type
    always_comb begin
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) edge_set[i] = update[i] && edge_match(EDGE_TYPE, ~stable[i]);
    end
    // register file: irqmask write, sticky edge capture where a new edge beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (wr && s1.address == IRQMASK) irqmask <= s1.writedata[WIDTH-1:0];
            edgecap <= (edgecap & ~edge_clr) | edge_set;
        end
    end
    // read data is reloaded from the current address every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s1.readdata <= '0;
        else          s1.readdata <= 32'(rd_sel);
    end
endmodule

// File: doc/pio_in_debounce_irq.md
# pio_in_debounce_irq

Parametrised Avalon-MM input PIO for the Nios system. It is the successor to the plain key/switch input port. Each input bit is synchronised, debounced, and edge-detected into a sticky edge-capture register. A maskable level interrupt is raised to the CPU from the captured edges. The block sits on the system interconnect as an s1 slave, with push-buttons or switches on `in_port`.

## Interface
- `WIDTH`, 4: number of input bits, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per bit, ≥2.
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles an input must hold a new level before it is accepted, ≥1.
- `EDGE_TYPE`, 0: edges captured; 0 = rising, 1 = falling, 2 = any.
- `RESET_VALUE`, 0: WIDTH-bit reset level of the synchroniser and stable registers.

Clock and reset are one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  raw asynchronous inputs.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, active-high.

## Operation
Register map (word addresses):
- 0 data: read returns the debounced stable value; writes ignored.
- 1 reserved: reads 0; writes ignored.
- 2 irqmask: read/write, bits [WIDTH-1:0].
- 3 edgecapture: read returns captured edges; a write clears each bit where `writedata` is 1 (write-1-to-clear).
- Bits [31:WIDTH] always read 0.

Per-bit path: synchroniser → debouncer → edge detect.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
- Counter clears whenever the synchronised bit equals the stable bit.
- Counter increments while the two differ.
- When the counter reaches DEBOUNCE_CYCLES-1 and the bits still differ, stable takes the synchronised value and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.

Edge capture:
- Set on the clock edge where stable updates, if the direction matches `EDGE_TYPE`.
- Sticky until cleared by a write.
- Set-and-clear in the same cycle on the same bit: set wins.

`irq` = OR over (edgecapture & irqmask), decoded from registers with no extra flop.

A write occurs when `chipselect`=1 and `write_n`=0.

Reset values:
- `readdata` = 0, `irq` = 0, irqmask = 0, edgecapture = 0, counters = 0.
- Synchroniser and stable registers = `RESET_VALUE`.
- With `RESET_VALUE` matching the idle input level, leaving reset produces no edges.
- Reset asserted mid-debounce aborts the count; no edge is captured.

## Timing
- `readdata` is loaded every clock from the current `address`, independent of `chipselect`. Read latency is 1 cycle; there are no wait states.
- Writes take effect on the clock edge where they are presented.
- Input step to synchroniser output: `SYNC_STAGES` cycles.
- Synchroniser output to stable update: `DEBOUNCE_CYCLES` cycles.
- Total latency, `in_port` step to data-register change: `SYNC_STAGES`+`DEBOUNCE_CYCLES` cycles.
- edgecapture sets on the same edge as the stable update. `irq` rises in that cycle if the bit is masked in.
- An irqmask write changes `irq` in the cycle after the write edge.
- An edgecapture clear drops `irq` in the cycle after the write edge, unless a new edge sets the bit on that same edge.

## Structure
- Shared package `pio_pkg`:
  - Register address constants: DATA=0, RSVD=1, IRQMASK=2, EDGECAP=3.
  - `EDGE_TYPE` encodings: RISE=0, FALL=1, ANY=2.
- Sub-module `pio_debounce_bit`, instantiated once per bit in a generate loop.
  - Contains the synchroniser, debounce counter and stable flop.
  - Outputs: `stable` and a one-cycle `update` pulse with the new level.
- Top level holds the register file, edge-capture logic, read mux and `irq`.

## Test plan
Bench configuration: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, RESET_VALUE=0.
- Reset: hold `in_port`=4'h0, release `reset_n` → reads of addresses 0 to 3 return 0; `irq`=0 throughout.
- Debounce glitch: `in_port[1]` high for 3 cycles then low → data stays 0 and edgecapture stays 0. Then hold high for 8 cycles → data reads 4'h2 exactly 6 cycles after the step, and edgecapture reads 4'h2.
- Interrupt: write irqmask=4'h2, then raise `in_port[1]` → `irq`=1 on the stable-update cycle. Write 4'h2 to address 3 → `irq`=0 the next cycle.
- Mask: mask=0 with an edge pending → `irq` stays 0. Write mask=4'hF → `irq`=1 the next cycle.
- Set/clear collision: write edgecapture clear on bit 0 on the same edge bit 0 rises → edgecapture bit 0 remains 1.
- Falling and any edge: rerun with EDGE_TYPE=1 and EDGE_TYPE=2 → a bit-3 1→0 transition is captured in both; a 0→1 transition is captured only with EDGE_TYPE=2. Mid-debounce reset → no capture.
